// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 status/cause/EPC registers and the
// exception/interrupt request for the pipelined MIPS core, next to MEM.
// Req is combinational and flushes the pipe in the same cycle.
// Optional build macro CP0_PRID_EN adds a read-only PRId at register 15.
module cp0_exc_ctrl
`ifdef CP0_PRID_EN
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2022
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
`ifdef CP0_PRID_EN
    localparam logic [4:0] REG_PRID  = 5'd15;
`endif

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] vpc_aligned;
    logic [31:0] epc_victim;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // The victim PC is always word-aligned; the low bits carry no information.
    logic unused_vpc_bits;
    assign unused_vpc_bits = ^VPC[1:0];

    assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

    // Request arbitration: nothing new is accepted while in the handler (EXL=1)
    always_comb begin
        int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
        exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
        Req     = ~reset & (int_req | exc_req);
    end

    // Restart address: a delay-slot victim restarts at its branch
    always_comb begin
        vpc_aligned = {VPC[31:2], 2'b00};
        epc_victim  = BDIn ? (vpc_aligned - 32'd4) : vpc_aligned;
    end

    // Register state: exception capture has priority over mtc0 and eret
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? 5'd0 : ExcCodeIn;
                cause_bd  <= BDIn;
                epc       <= epc_victim;
            end else begin
                if (WE && (A2 == REG_SR)) begin
                    sr_im  <= DIn[15:10];
                    sr_exl <= DIn[1];
                    sr_ie  <= DIn[0];
                end
                if (WE && (A2 == REG_EPC)) begin
                    epc <= {DIn[31:2], 2'b00};
                end
                // eret overrides an mtc0 to SR.EXL in the same cycle
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read port shows pre-write values; bypassing lives in the hazard unit
    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc;
`ifdef CP0_PRID_EN
            REG_PRID:  DOut = PRID_VALUE;
`endif
            default:   DOut = 32'd0;
        endcase
    end

    assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: the driver computes expected Req/DOut/EPCOut
// from a word-level model of the CP0 rules and queues them; a negedge monitor
// pops and compares.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2, exc;
    logic [31:0] din, vpc;
    logic        we, bd, exlclr;
    logic [5:0]  hw;
    logic [31:0] dout, epc_out;
    logic        req;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .DIn(din), .WE(we),
        .VPC(vpc), .BDIn(bd), .ExcCodeIn(exc), .HWInt(hw), .EXLClr(exlclr),
        .DOut(dout), .EPCOut(epc_out), .Req(req)
    );

    typedef struct {
        logic        req;
        logic [31:0] dout;
        logic [31:0] epco;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    // model state held as full architectural words
    logic [31:0] m_sr, m_cause, m_epc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    endtask

    // monitor: compare queued expectations mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("Req", {31'd0, req}, {31'd0, e.req});
            chk("DOut", dout, e.dout);
            chk("EPCOut", epc_out, e.epco);
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] r);
        case (r)
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
`ifdef CP0_PRID_EN
            5'd15: return 32'h0000_2022;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // apply one cycle of inputs (called #1 after a posedge), queue expectation, advance model
    task automatic step(input logic rst, input logic [4:0] ra, input logic [4:0] wa,
                        input logic [31:0] wd, input logic wen, input logic [31:0] pc,
                        input logic bds, input logic [4:0] code, input logic [5:0] lines,
                        input logic clr);
        exp_t e;
        bit ie, exl, irq, xrq, r;
        reset = rst; a1 = ra; a2 = wa; din = wd; we = wen; vpc = pc;
        bd = bds; exc = code; hw = lines; exlclr = clr;
        ie  = m_sr[0];
        exl = m_sr[1];
        irq = ((lines & m_sr[15:10]) != 6'd0) && ie && !exl;
        xrq = (code != 5'd0) && !exl;
        r   = !rst && (irq || xrq);
        e.req  = r;
        e.dout = model_read(ra);
        e.epco = m_epc;
        q.push_back(e);
        if (rst) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, lines} << 10);
            if (r) begin
                m_sr = m_sr | 32'h2;
                m_cause = (m_cause & ~32'h8000_007C) | ({27'd0, (irq ? 5'd0 : code)} << 2)
                          | (bds ? 32'h8000_0000 : 32'h0);
                m_epc = (pc & ~32'h3) - (bds ? 32'd4 : 32'd0);
            end else begin
                if (wen && wa == 5'd12) m_sr = wd & 32'h0000_FC03;
                if (wen && wa == 5'd14) m_epc = wd & ~32'h3;
                if (clr) m_sr = m_sr & ~32'h2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] ra);
        step(0, ra, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; a1 = 0; a2 = 0; din = 0; we = 0; vpc = 0;
        bd = 0; exc = 0; hw = 0; exlclr = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        repeat (2) @(posedge clk);
        #1;
        // post-reset: every register number reads as the model says (0 / PRId)
        for (int i = 0; i < 32; i++) idle(i[4:0]);

        // synchronous exception, EXL blocks a held code
        step(0, 14, 0, 0, 0, 32'h3008, 0, 4, 0, 0);
        step(0, 14, 0, 0, 0, 32'h3008, 0, 4, 0, 0);
        step(0, 13, 0, 0, 0, 32'h3008, 0, 4, 0, 0);
        idle(12);
        step(0, 12, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(12);

        // delay slot victim
        step(0, 0, 0, 0, 0, 32'h3010, 1, 12, 0, 0);
        idle(14);
        idle(13);
        step(0, 12, 0, 0, 0, 0, 0, 0, 0, 1);

        // interrupt enabled, then disabled
        step(0, 12, 12, 32'h0000_FC01, 1, 0, 0, 0, 0, 0);
        step(0, 12, 0, 0, 0, 0, 0, 0, 6'b000100, 0);
        idle(13);
        step(0, 12, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 12, 12, 32'h0000_FC00, 1, 0, 0, 0, 0, 0);
        step(0, 13, 0, 0, 0, 0, 0, 0, 6'b000100, 0);
        step(0, 13, 0, 0, 0, 0, 0, 0, 6'b000100, 0);

        // interrupt beats exception
        step(0, 12, 12, 32'h0000_0401, 1, 0, 0, 0, 0, 0);
        step(0, 12, 0, 0, 0, 32'h3018, 0, 10, 6'b000001, 0);
        idle(13);

        // eret, then mtc0 to EPC suppressed by an exception
        step(0, 12, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(12);
        step(0, 14, 14, 32'h4000, 1, 32'h3020, 0, 4, 0, 0);
        idle(14);

        // mtc0 SR with eret: EXLClr wins on EXL
        step(0, 12, 12, 32'h0000_FC03, 1, 0, 0, 0, 0, 1);
        idle(12);

        // PRId, then reset while in the handler
        idle(15);
        step(0, 12, 0, 0, 0, 32'h3030, 0, 7, 0, 0);
        step(1, 12, 0, 0, 0, 32'h3030, 0, 7, 0, 0);
        idle(12);
        idle(13);

        // randomized traffic with biased register selection
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] ra, wa, code;
            logic [31:0] wd;
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) wd[0] = 1'b1;
            code = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            step(($urandom_range(0, 60) == 0), ra, wa, wd, ($urandom_range(0, 2) == 0),
                 $urandom, 1'($urandom), code, 6'($urandom), ($urandom_range(0, 4) == 0));
        end

        idle(0);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
